nibble_add_seq: RTL and testbench
=================================

# nibble_add_seq

Multi-cycle sequencer that adds two WIDTH-bit operands by reusing one 4-bit ripple-carry slice, one nibble per clock, LSB nibble first. A registered carry links successive nibbles. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area where a full-width adder is not justified.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8; NIB = WIDTH/4 nibble steps per operation
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set offered
- in_ready  out  1  block can accept; equals (state == IDLE)
- a  in  WIDTH  operand A, sampled only on accept
- b  in  WIDTH  operand B, sampled only on accept
- cin  in  1  carry-in to nibble 0, sampled only on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  registered result
- cout  out  1  carry out of MSB, registered
- busy  out  1  state != IDLE
- ovf  out  1  signed overflow; present only with macro (see Configuration)

## Operation
- Reset, asynchronous: state=IDLE; idx=0; carry=0; sum=0; cout=0; out_valid=0; ovf=0; operand registers=0. in_ready=1 once rst deasserts.
- IDLE: on in_valid && in_ready at a rising edge:
  - latch a, b
  - carry<=cin, idx<=0, sum<=0
  - go to RUN
- RUN, each cycle:
  - slice computes a[4*idx+:4] + b[4*idx+:4] + carry
  - sum[4*idx+:4] <= slice sum; carry <= slice carry-out; idx <= idx+1
  - on idx == NIB-1: cout <= slice carry-out, out_valid <= 1, go to DONE
- DONE: sum, cout, ovf and out_valid are held stable. On out_valid && out_ready: out_valid<=0, go to IDLE.
- Input handling: in_valid is ignored in RUN and DONE, and a/b/cin changes there have no effect. No new operation is accepted in the same cycle as result handoff.
- Arithmetic: result is unsigned modulo 2^WIDTH. {cout,sum} == a + b + cin exactly.
- idx width is clog2(NIB). idx never exceeds NIB-1 and resets to 0 on accept.
- Reset mid-operation, any state: the operation is dropped. All outputs return to their reset values immediately, with no partial result. The first accept after reset behaves exactly as after power-up.

## Timing
- Accept at edge E0. RUN occupies edges E1..E_NIB. out_valid is high after edge E_NIB, so latency is NIB cycles accept-to-result (4 for WIDTH=16).
- Minimum accept-to-accept spacing is NIB+2 cycles: NIB RUN cycles, at least one DONE cycle, and one IDLE cycle.
- The combinational path is one 4-bit ripple slice plus the carry flop only. No path scales with WIDTH other than the nibble mux.
- in_ready, busy: decoded from state register, glitch-free, no combinational dependence on in_valid/out_ready.

## Configuration
- NIBBLE_ADD_SEQ_OVF_EN defined:
  - ovf port exists
  - on the final nibble, ovf <= slice carry-out XOR slice carry into bit 3 (two's-complement overflow of a+b+cin)
  - ovf is held in DONE, cleared on accept and on reset
- Macro undefined: no ovf port, and no carry-into-bit-3 tap is used.

## Structure
- Shared package nibble_add_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NIBBLE_W=4 constant, and a clog2 function for idx width.
- Natural sub-module: nibble_add4, a purely combinational 4-bit ripple-carry slice.
  - Ports: a[3:0], b[3:0], ci, s[3:0], co, plus c3 (carry into bit 3) for overflow.
  - Built from per-bit full-adder equations s=a^b^c, co=ab|bc|ca.
- Top: FSM, idx counter, carry flop, operand registers, nibble mux, and the sum write-enable decode.

## Test plan
- a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0; out_valid rises exactly 4 cycles after accept.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples through all four nibble steps); a=16'hFFFF, b=0, cin=1 -> same result.
- Backpressure: result pending, out_ready=0 for 5 cycles with in_valid=1 and changing a/b -> sum, cout, out_valid stable; in_ready=0; no second operation starts; after out_ready, in_ready=1 the next cycle.
- Reset during RUN at idx=2 -> sum=0, cout=0, out_valid=0, busy=0 asynchronously; after release, a=16'h00FF, b=16'h0001 -> sum=16'h0100, cout=0.
- Back-to-back ops with out_ready tied 1 -> accepts spaced exactly NIB+2=6 cycles; each result matches the reference sum (randomized 200 pairs, WIDTH=16 and WIDTH=8).
- With NIBBLE_ADD_SEQ_OVF_EN: 16'h7FFF+16'h0001 -> sum=16'h8000, ovf=1, cout=0; 16'h8000+16'hFFFF -> sum=16'h7FFF, ovf=1, cout=1; 16'h1234+16'h4321 -> ovf=0.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width, idx sizing.
package nibble_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Bits needed to index n nibbles; never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit ripple-carry slice built from per-bit full adders.
module nibble_add4
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (b[i] & c[i]) | (c[i] & a[i]);
        end
    end

    assign co = c[NIBBLE_W];
    assign c3 = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: one 4-bit slice reused NIB times, LSB nibble first, valid/ready on both sides.
// Define NIBBLE_ADD_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module nibble_add_seq
    import nibble_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIB = WIDTH / NIBBLE_W;
    localparam int unsigned IW  = clog2(NIB);

    typedef logic [IW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(NIB - 1);

    state_t              state;
    idx_t                idx;
    logic                carry;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_co;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic                nib_c3;
`else
    logic                nib_c3_unused;
`endif

    assign nib_a    = a_r[NIBBLE_W*idx +: NIBBLE_W];
    assign nib_b    = b_r[NIBBLE_W*idx +: NIBBLE_W];
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    nibble_add4 u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry),
        .s  (nib_s),
        .co (nib_co),
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        .c3 (nib_c3)
`else
        .c3 (nib_c3_unused)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                        ovf   <= 1'b0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[NIBBLE_W*idx +: NIBBLE_W] <= nib_s;
                    carry <= nib_co;
                    // Explicit wrap keeps idx within NIB-1 when NIB is not a power of two.
                    if (idx == LAST) begin
                        idx       <= '0;
                        cout      <= nib_co;
                        out_valid <= 1'b1;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                        ovf       <= nib_co ^ nib_c3;
`endif
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed and back-to-back checks of nibble_add_seq at WIDTH=16 and WIDTH=8.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid16 = 1'b0, in_ready16, cin16 = 1'b0;
    logic        out_valid16, out_ready16 = 1'b0, cout16, busy16;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        in_valid8 = 1'b0, in_ready8, cin8 = 1'b0;
    logic        out_valid8, out_ready8 = 1'b0, cout8, busy8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic        ovf16, ovf8;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .busy(busy16)
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        , .ovf(ovf16)
`endif
    );

    nibble_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the 16-bit DUT idle; returns cycles from accept to out_valid.
    task automatic start16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                           output int lat);
        check("in_ready_idle", 32'(in_ready16), 32'd1);
        a16 = ta; b16 = tb_; cin16 = tc; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handoff16();
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("in_ready_after_handoff", 32'(in_ready16), 32'd1);
        check("out_valid_after_handoff", 32'(out_valid16), 32'd0);
    endtask

    initial begin
        int lat;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
        vecs[9] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum16), 32'd0);
        check("rst_cout", 32'(cout16), 32'd0);
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready16), 32'd1);

        // Table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            start16(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_sum", i), 32'(sum16), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(cout16), 32'(vecs[i].cout));
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf16), 32'(vecs[i].ovf));
`endif
            handoff16();
        end

        // Backpressure: result held while in_valid and operands churn
        start16(16'h1234, 16'h4321, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        in_valid16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a16 = 16'h1111 * 16'(i + 1);
            b16 = ~a16;
            cin16 = 1'(i);
            @(negedge clk);
            check("bp_sum", 32'(sum16), 32'h5555);
            check("bp_cout", 32'(cout16), 32'd0);
            check("bp_out_valid", 32'(out_valid16), 32'd1);
            check("bp_in_ready", 32'(in_ready16), 32'd0);
        end
        in_valid16 = 1'b0;
        handoff16();
        check("bp_no_second_op", 32'(busy16), 32'd0);

        // Reset during RUN with idx=2: nibbles 0 and 1 already written
        a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun_partial_sum", 32'(sum16), 32'h0033);
        check("midrun_busy", 32'(busy16), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun_rst_sum", 32'(sum16), 32'd0);
        check("midrun_rst_cout", 32'(cout16), 32'd0);
        check("midrun_rst_out_valid", 32'(out_valid16), 32'd0);
        check("midrun_rst_busy", 32'(busy16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start16(16'h00FF, 16'h0001, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_sum", 32'(sum16), 32'h0100);
        check("post_rst_cout", 32'(cout16), 32'd0);
        handoff16();

        // Back-to-back, WIDTH=16: spacing NIB+2 = 6
        begin
            logic [16:0] expq[$];
            logic [16:0] e;
            int acc = 0, done = 0, last = -1, cyc = 0;
            out_ready16 = 1'b1;
            while (done < 200 && cyc < 5000) begin
                if (out_valid16) begin
                    if (expq.size() == 0) begin
                        check("b2b16_spurious", 32'(out_valid16), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check("b2b16_result", 32'({cout16, sum16}), 32'(e));
                    end
                    done++;
                end
                if (in_ready16 && acc < 200) begin
                    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
                    expq.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
                    if (last >= 0) check("b2b16_spacing", 32'(cyc - last), 32'd6);
                    last = cyc;
                    acc++;
                    in_valid16 = 1'b1;
                end else if (acc >= 200) begin
                    in_valid16 = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            check("b2b16_completed", 32'(done), 32'd200);
            in_valid16 = 1'b0;
            out_ready16 = 1'b0;
        end

        // Back-to-back, WIDTH=8: spacing NIB+2 = 4
        begin
            logic [8:0] expq[$];
            logic [8:0] e;
            int acc = 0, done = 0, last = -1, cyc = 0;
            out_ready8 = 1'b1;
            while (done < 200 && cyc < 5000) begin
                if (out_valid8) begin
                    if (expq.size() == 0) begin
                        check("b2b8_spurious", 32'(out_valid8), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check("b2b8_result", 32'({cout8, sum8}), 32'(e));
                    end
                    done++;
                end
                if (in_ready8 && acc < 200) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                    expq.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
                    if (last >= 0) check("b2b8_spacing", 32'(cyc - last), 32'd4);
                    last = cyc;
                    acc++;
                    in_valid8 = 1'b1;
                end else if (acc >= 200) begin
                    in_valid8 = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            check("b2b8_completed", 32'(done), 32'd200);
            in_valid8 = 1'b0;
            out_ready8 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
